// File: rtl/timer_event_irq.sv
// Event counter with threshold match, hold/auto-reload modes and an APB-lite
// register file. The trig input is asynchronous and is synchronised to PCLK.
module timer_event_irq (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       trig,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [1:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       irq
);

    typedef enum logic [1:0] {DIS, CNT, HOLD} state_t;

    state_t     state_q, state_d;
    logic       s1_q, s2_q, s3_q;
    logic       v1_q, v2_q, arm_q, event_q;
    logic [2:0] ctrl_q, ctrl_d;
    logic [7:0] thresh_q, thresh_d;
    logic [7:0] count_q, count_d;
    logic       pend_q, pend_d, ovr_q, ovr_d;

    logic       wr, rd, wr_ctrl, wr_thresh, wr_status, wr_count;
    logic       ev, match, pend_set, ovr_set, pend_clr, ovr_clr;
    logic [7:0] count_inc;

    assign wr        = PSEL & PENABLE & PWRITE;
    assign rd        = PSEL & PENABLE & ~PWRITE;
    assign wr_ctrl   = wr && (PADDR == 2'd0);
    assign wr_thresh = wr && (PADDR == 2'd1);
    assign wr_status = wr && (PADDR == 2'd2);
    assign wr_count  = wr && (PADDR == 2'd3);
    assign pend_clr  = wr_status & PWDATA[0];
    assign ovr_clr   = wr_status & PWDATA[1];

    // A COUNT write on the same edge swallows the event entirely.
    assign ev        = event_q & ~wr_count;
    assign count_inc = count_q + 8'd1;
    assign match     = ev && (state_q == CNT) && (thresh_q != '0) && (count_inc == thresh_q);

    // v1/v2 mark the synchroniser as holding real samples; arm_q requires trig to be
    // seen low first, so a trig held high through reset release is not an edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            arm_q   <= 1'b0;
            event_q <= 1'b0;
        end else begin
            s1_q    <= trig;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            v1_q    <= 1'b1;
            v2_q    <= v1_q;
            arm_q   <= arm_q | (v2_q & ~s2_q);
            event_q <= s2_q & ~s3_q & arm_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        thresh_d = thresh_q;
        count_d  = count_q;
        pend_set = 1'b0;
        ovr_set  = 1'b0;
        case (state_q)
            DIS: begin
                if (ctrl_q[0]) state_d = CNT;
            end
            CNT: begin
                if (match) begin
                    pend_set = 1'b1;
                    ovr_set  = pend_q;
                    if (ctrl_q[2]) begin
                        count_d = '0;
                    end else begin
                        count_d = thresh_q;
                        state_d = HOLD;
                    end
                end else if (ev) begin
                    count_d = count_inc;
                end
                if (!ctrl_q[0]) state_d = DIS;
            end
            HOLD: begin
                if (ev) ovr_set = 1'b1;
                if (!ctrl_q[0]) begin
                    state_d = DIS;
                end else if (pend_clr) begin
                    state_d = CNT;
                    count_d = '0;
                end
            end
            default: state_d = DIS;
        endcase
        if (wr_count)  count_d  = '0;
        if (wr_ctrl)   ctrl_d   = PWDATA[2:0];
        if (wr_thresh) thresh_d = PWDATA;
        pend_d = pend_set | (pend_q & ~pend_clr);
        ovr_d  = ovr_set  | (ovr_q  & ~ovr_clr);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= DIS;
            ctrl_q   <= '0;
            thresh_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            thresh_q <= thresh_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (rd) begin
            case (PADDR)
                2'd0:    PRDATA = {5'b0, ctrl_q};
                2'd1:    PRDATA = thresh_q;
                2'd2:    PRDATA = {6'b0, ovr_q, pend_q};
                default: PRDATA = count_q;
            endcase
        end
    end

    assign PREADY = 1'b1;
    assign irq    = pend_q & ctrl_q[1];

endmodule

// File: tb/tb_timer_event_irq.sv
// Self-checking bench for timer_event_irq: directed scenarios plus a randomized
// operation sequence scored against a transaction-level model.
module tb_timer_event_irq;

    logic       PCLK = 1'b0;
    logic       PRESET, trig, PSEL, PENABLE, PWRITE;
    logic [1:0] PADDR;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, irq;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    bit       m_en, m_irqen, m_auto, m_hold, m_pend, m_ovr;
    bit [7:0] m_thresh, m_count;

    timer_event_irq dut (
        .PCLK(PCLK), .PRESET(PRESET), .trig(trig), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model (register-level rules) ----------------
    function automatic void m_reset();
        m_en = 0; m_irqen = 0; m_auto = 0; m_hold = 0; m_pend = 0; m_ovr = 0;
        m_thresh = 0; m_count = 0;
    endfunction

    function automatic void m_write(input bit [1:0] a, input bit [7:0] d);
        case (a)
            2'd0: begin
                m_en = d[0]; m_irqen = d[1]; m_auto = d[2];
                if (!m_en) m_hold = 0;
            end
            2'd1: m_thresh = d;
            2'd2: begin
                if (d[0]) begin
                    m_pend = 0;
                    if (m_hold) begin m_hold = 0; m_count = 0; end
                end
                if (d[1]) m_ovr = 0;
            end
            default: m_count = 0;
        endcase
    endfunction

    function automatic void m_event();
        bit [7:0] nxt;
        if (!m_en) return;
        if (m_hold) begin m_ovr = 1; return; end
        nxt = m_count + 8'd1;
        if (m_thresh != 0 && nxt == m_thresh) begin
            if (m_pend) m_ovr = 1;
            m_pend = 1;
            if (m_auto) m_count = 0;
            else begin m_count = m_thresh; m_hold = 1; end
        end else begin
            m_count = nxt;
        end
    endfunction

    function automatic bit [7:0] m_reg(input bit [1:0] a);
        case (a)
            2'd0:    return {5'b0, m_auto, m_irqen, m_en};
            2'd1:    return m_thresh;
            2'd2:    return {6'b0, m_ovr, m_pend};
            default: return m_count;
        endcase
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [1:0] a, input logic [7:0] d);
        PSEL = 1; PWRITE = 1; PADDR = a; PWDATA = d; PENABLE = 0;
        tick(1);
        PENABLE = 1;
        tick(1);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [1:0] a, output logic [7:0] d);
        PSEL = 1; PWRITE = 0; PADDR = a; PENABLE = 0;
        tick(1);
        PENABLE = 1;
        #2 d = PRDATA;
        tick(1);
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic pulse();
        trig = 1;
        tick(3);
        trig = 0;
        tick(4);
    endtask

    task automatic do_reset();
        PRESET = 1; trig = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        tick(2);
        PRESET = 0;
        tick(3);
        m_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] rd;
        PRESET = 1; trig = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        tick(2);
        n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
        n_total++; if (PREADY !== 1'b1) $display("FAIL reset_pready: got %b want 1", PREADY); else n_pass++;
        n_total++; if (PRDATA !== 8'h00) $display("FAIL reset_prdata: got %h want 00", PRDATA); else n_pass++;
        PRESET = 0;
        tick(3);
        m_reset();
        for (int unsigned a = 0; a < 4; a++) begin
            apb_read(2'(a), rd);
            n_total++; if (rd !== 8'h00) $display("FAIL reset_reg%0d: got %h want 00", a, rd); else n_pass++;
        end
    endtask

    task automatic test_latency();
        do_reset();
        apb_write(2'd0, 8'h01);
        tick(2);
        trig = 1;
        tick(2);
        PSEL = 1; PWRITE = 0; PADDR = 2'd3; PENABLE = 0;
        tick(1);
        PENABLE = 1;
        #2;
        n_total++; if (PRDATA !== 8'h00) $display("FAIL latency_edge3: got %h want 00", PRDATA); else n_pass++;
        tick(1);
        #2;
        n_total++; if (PRDATA !== 8'h01) $display("FAIL latency_edge4: got %h want 01", PRDATA); else n_pass++;
        PSEL = 0; PENABLE = 0;
        trig = 0;
        tick(4);
    endtask

    task automatic test_count_hold();
        logic [7:0] rd;
        do_reset();
        apb_write(2'd1, 8'd3);
        apb_write(2'd0, 8'h03);
        for (int unsigned i = 1; i <= 3; i++) begin
            pulse();
            apb_read(2'd3, rd);
            n_total++; if (rd !== 8'(i)) $display("FAIL hold_count%0d: got %h want %h", i, rd, 8'(i)); else n_pass++;
        end
        apb_read(2'd2, rd);
        n_total++; if (rd !== 8'h01) $display("FAIL hold_status: got %h want 01", rd); else n_pass++;
        n_total++; if (irq !== 1'b1) $display("FAIL hold_irq: got %b want 1", irq); else n_pass++;
        pulse();
        apb_read(2'd3, rd);
        n_total++; if (rd !== 8'h03) $display("FAIL hold_count4: got %h want 03", rd); else n_pass++;
        apb_read(2'd2, rd);
        n_total++; if (rd !== 8'h03) $display("FAIL hold_ovr: got %h want 03", rd); else n_pass++;
        apb_write(2'd2, 8'h01);
        apb_read(2'd3, rd);
        n_total++; if (rd !== 8'h00) $display("FAIL hold_release_count: got %h want 00", rd); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL hold_release_irq: got %b want 0", irq); else n_pass++;
        pulse();
        apb_read(2'd3, rd);
        n_total++; if (rd !== 8'h01) $display("FAIL hold_resume: got %h want 01", rd); else n_pass++;
    endtask

    task automatic test_auto_reload();
        logic [7:0] rd;
        logic [7:0] exp_cnt [5] = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
        logic [7:0] exp_st  [5] = '{8'h00, 8'h01, 8'h01, 8'h03, 8'h03};
        do_reset();
        apb_write(2'd1, 8'd2);
        apb_write(2'd0, 8'h07);
        for (int unsigned i = 0; i < 5; i++) begin
            pulse();
            apb_read(2'd3, rd);
            n_total++; if (rd !== exp_cnt[i]) $display("FAIL auto_count%0d: got %h want %h", i, rd, exp_cnt[i]); else n_pass++;
            apb_read(2'd2, rd);
            n_total++; if (rd !== exp_st[i]) $display("FAIL auto_status%0d: got %h want %h", i, rd, exp_st[i]); else n_pass++;
        end
    endtask

    task automatic test_collision();
        logic [7:0] rd;
        do_reset();
        apb_write(2'd1, 8'd1);
        apb_write(2'd0, 8'h03);
        tick(1);
        trig = 1;
        tick(2);
        PSEL = 1; PWRITE = 1; PADDR = 2'd2; PWDATA = 8'h01; PENABLE = 0;
        tick(1);
        PENABLE = 1;
        tick(1);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        trig = 0;
        tick(4);
        apb_read(2'd2, rd);
        n_total++; if (rd !== 8'h01) $display("FAIL collide_pend: got %h want 01", rd); else n_pass++;
        n_total++; if (irq !== 1'b1) $display("FAIL collide_irq: got %b want 1", irq); else n_pass++;
        pulse();
        apb_read(2'd3, rd);
        n_total++; if (rd !== 8'h01) $display("FAIL collide_hold_count: got %h want 01", rd); else n_pass++;
        apb_read(2'd2, rd);
        n_total++; if (rd !== 8'h03) $display("FAIL collide_hold_ovr: got %h want 03", rd); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] rd;
        do_reset();
        apb_write(2'd0, 8'h03);
        repeat (257) pulse();
        apb_read(2'd3, rd);
        n_total++; if (rd !== 8'h01) $display("FAIL wrap_count: got %h want 01", rd); else n_pass++;
        apb_read(2'd2, rd);
        n_total++; if (rd !== 8'h00) $display("FAIL wrap_status: got %h want 00", rd); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL wrap_irq: got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_reset_in_hold();
        logic [7:0] rd;
        do_reset();
        apb_write(2'd1, 8'd1);
        apb_write(2'd0, 8'h03);
        pulse();
        n_total++; if (irq !== 1'b1) $display("FAIL rsthold_pre_irq: got %b want 1", irq); else n_pass++;
        trig = 1;
        tick(2);
        #2 PRESET = 1;
        #1;
        n_total++; if (irq !== 1'b0) $display("FAIL rsthold_async_irq: got %b want 0", irq); else n_pass++;
        tick(1);
        PRESET = 0;
        m_reset();
        for (int unsigned a = 0; a < 4; a++) begin
            apb_read(2'(a), rd);
            n_total++; if (rd !== 8'h00) $display("FAIL rsthold_reg%0d: got %h want 00", a, rd); else n_pass++;
        end
        apb_write(2'd0, 8'h01);
        tick(8);
        apb_read(2'd3, rd);
        n_total++; if (rd !== 8'h00) $display("FAIL rsthold_no_spurious: got %h want 00", rd); else n_pass++;
        trig = 0;
        tick(4);
        pulse();
        apb_read(2'd3, rd);
        n_total++; if (rd !== 8'h01) $display("FAIL rsthold_new_edge: got %h want 01", rd); else n_pass++;
    endtask

    task automatic test_apb();
        logic [7:0] rd;
        do_reset();
        apb_write(2'd0, 8'hFF);
        apb_read(2'd0, rd);
        n_total++; if (rd !== 8'h07) $display("FAIL apb_ctrl: got %h want 07", rd); else n_pass++;
        PSEL = 1; PWRITE = 0; PADDR = 2'd0; PENABLE = 0;
        #2;
        n_total++; if (PRDATA !== 8'h00) $display("FAIL apb_setup_prdata: got %h want 00", PRDATA); else n_pass++;
        PSEL = 0;
        tick(1);
        apb_write(2'd1, 8'hA5);
        apb_read(2'd1, rd);
        n_total++; if (rd !== 8'hA5) $display("FAIL apb_thresh: got %h want a5", rd); else n_pass++;
        apb_write(2'd1, 8'h00);
        pulse();
        pulse();
        apb_read(2'd3, rd);
        n_total++; if (rd !== 8'h02) $display("FAIL apb_count_pre: got %h want 02", rd); else n_pass++;
        apb_write(2'd3, 8'h5A);
        apb_read(2'd3, rd);
        n_total++; if (rd !== 8'h00) $display("FAIL apb_count_clear: got %h want 00", rd); else n_pass++;
        n_total++; if (PRDATA !== 8'h00) $display("FAIL apb_idle_prdata: got %h want 00", PRDATA); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] rd, d;
        int unsigned op;
        do_reset();
        for (int unsigned i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3, 4: begin pulse(); m_event(); end
                5: begin d = 8'($urandom); apb_write(2'd0, d); m_write(2'd0, d); end
                6: begin d = 8'($urandom_range(0, 4)); apb_write(2'd1, d); m_write(2'd1, d); end
                7: begin d = 8'($urandom_range(0, 3)); apb_write(2'd2, d); m_write(2'd2, d); end
                8: begin d = 8'($urandom); apb_write(2'd3, d); m_write(2'd3, d); end
                default: tick(3);
            endcase
            for (int unsigned a = 0; a < 4; a++) begin
                apb_read(2'(a), rd);
                n_total++;
                if (rd !== m_reg(2'(a)))
                    $display("FAIL rand_op%0d_reg%0d: got %h want %h", i, a, rd, m_reg(2'(a)));
                else n_pass++;
            end
            n_total++;
            if (irq !== (m_pend & m_irqen)) $display("FAIL rand_op%0d_irq: got %b want %b", i, irq, m_pend & m_irqen);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_count_hold();
        test_auto_reload();
        test_collision();
        test_wrap();
        test_reset_in_hold();
        test_apb();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/timer_event_irq.md
TIMER_EVENT_IRQ -- requirements
Module: timer_event_irq

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 SHALL provide the following ports (name, direction, width, meaning):
- PCLK  in  1  system clock, the single clock; all state on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- trig  in  1  match level from the comparator stage; generated on the prescaled clock domain, so it is treated as asynchronous.
- PSEL  in  1  APB slave select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  2  register address.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data.
- PREADY  out  1  tied to 1 (no wait states).
- irq  out  1  interrupt request, level.
REQ-003 SHALL implement one clock domain (PCLK); reset is asynchronous and active-high (PRESET).

Function
REQ-004 SHALL synchronise trig through two flops (s1, s2) plus a history flop s3; event = s2 & ~s3 (one PCLK pulse per trig rising edge).
REQ-005 SHALL make event visible in COUNT on the 4th PCLK rising edge after trig rises, given setup met.
REQ-006 SHALL implement the register map as follows; reads apply to all four addresses.
- 0 CTRL rw: bit0 EN, bit1 IRQ_EN, bit2 AUTO, bits7:3 read 0.
- 1 THRESH rw: 8 bits.
- 2 STATUS: bit0 PEND, bit1 OVR; write-1-to-clear per bit.
- 3 COUNT: read-only; any write clears it to 0.
REQ-007 SHALL perform a write only when PSEL & PENABLE & PWRITE, committing on that edge.
REQ-008 SHALL drive PRDATA combinationally with the addressed register when PSEL & PENABLE & ~PWRITE, and 0x00 otherwise.
REQ-009 SHALL implement a 3-state FSM: DIS, CNT, HOLD.
REQ-010 SHALL use these FSM transitions:
- DIS -> CNT when EN = 1.
- CNT -> DIS when EN = 0.
- HOLD -> DIS when EN = 0.
- CNT -> HOLD on a match when AUTO = 0.
- HOLD -> CNT when PEND is cleared by write-1.
REQ-011 SHALL count in CNT: each event sets COUNT to COUNT+1, 8-bit with wrap-around from 255 to 0.
REQ-012 SHALL detect a match as event with COUNT+1 == THRESH and THRESH != 0.
- On a match: set PEND.
- On a match with AUTO = 1: COUNT <= 0, remain in CNT.
- On a match with AUTO = 0: COUNT <= THRESH, go to HOLD.
REQ-013 SHALL never match while THRESH = 0; COUNT wraps freely.
REQ-014 SHALL ignore events in DIS, leaving COUNT unchanged.
REQ-015 SHALL hold COUNT in HOLD; any event there sets OVR.
REQ-016 SHALL set OVR in CNT if a match occurs while PEND is already 1.
REQ-017 SHALL set COUNT <= 0 when leaving HOLD on a PEND clear.
REQ-018 SHALL drive irq = PEND & IRQ_EN, registered-source with no combinational path from APB inputs.
REQ-019 SHALL resolve a same-edge write-1-to-clear of PEND/OVR and a hardware set of the same bit as set wins; the FSM then remains in, or enters, HOLD when AUTO = 0.
REQ-020 SHALL resolve a same-edge COUNT write and event as write wins: COUNT = 0 and the event is dropped.
REQ-021 SHALL use the new THRESH value for match evaluation from the next edge after a THRESH write.
REQ-022 SHALL NOT reset COUNT, PEND or OVR when EN is cleared; COUNT resumes from its held value on re-enable.

Reset
REQ-023 SHALL set all of the following asynchronously while PRESET = 1:
- CTRL = 0x00, THRESH = 0x00, STATUS = 0x00, COUNT = 0x00.
- s1, s2, s3 = 0.
- FSM = DIS.
- irq = 0, PRDATA = 0x00, PREADY = 1.
REQ-024 SHALL release reset without generating a spurious event, even if trig is high at release.
REQ-025 SHALL return to the reset state when PRESET is asserted mid-count or in HOLD, with no irq glitch to 1.

Verification
REQ-026 Count-and-hold:
- Stimulus: THRESH = 3, CTRL = 0x03, three trig pulses.
- Response: COUNT 1, 2, 3; PEND = 1 and irq = 1 after the 3rd event; FSM in HOLD.
- Then a 4th pulse: COUNT stays 3 and OVR = 1.
REQ-027 Auto-reload:
- Stimulus: THRESH = 2, CTRL = 0x07, five pulses.
- Response: COUNT sequence 1, 0, 1, 0, 1; PEND set on the 2nd event; OVR set on the 4th event.
REQ-028 Clear/set collision: a write of STATUS = 0x01 on the same edge as a matching event leaves PEND = 1.
REQ-029 Wrap:
- Stimulus: THRESH = 0, EN = 1, 257 pulses.
- Response: COUNT = 1; PEND = 0; irq = 0.
REQ-030 Reset during operation:
- Stimulus: PRESET pulse in HOLD with trig held high through reset release.
- Response: all registers 0x00; irq = 0; no event counted after re-enable until trig falls and rises again.
REQ-031 APB read/write:
- Stimulus: write 0xFF to CTRL, then read it back; write 0x5A to COUNT.
- Response: CTRL reads back 0x07 (bits 7:3 read 0); COUNT reads 0x00 after the write; PRDATA = 0x00 outside the access phase.
